// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing outputs of the VGA sync generator (pixel enable, coordinates, syncs, strobes).
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_start;
    logic       frame_start;
    modport master (output p_tick, x_pos, y_pos, hsync, vsync, video_on, line_start, frame_start);
    modport slave  (input  p_tick, x_pos, y_pos, hsync, vsync, video_on, line_start, frame_start);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with pixel-rate divider, h/v counters, registered syncs and strobes.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] VS_BEG   = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 15) begin : g_param_err
        $error("vga_sync_gen: totals must fit 10-bit counters and CLK_DIV must be 1..15");
    end
    logic [3:0] div_cnt;
    logic [9:0] x_pos, y_pos, x_nxt, y_nxt;
    logic       p_tick, hsync, vsync, video_on;
    always_comb begin
        p_tick = (div_cnt == DIV_LAST) && !reset;
        x_nxt  = p_tick ? ((x_pos == H_LAST) ? '0 : x_pos + 10'd1) : x_pos;
        y_nxt  = (p_tick && x_pos == H_LAST) ? ((y_pos == V_LAST) ? '0 : y_pos + 10'd1) : y_pos;
    end
    // Syncs and video_on decode the next-state counters so they line up with x_pos/y_pos.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            x_pos    <= '0;
            y_pos    <= '0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
            video_on <= 1'b1;
        end else begin
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 4'd1;
            x_pos    <= x_nxt;
            y_pos    <= y_nxt;
            hsync    <= ({1'b0, x_nxt} >= HS_BEG && {1'b0, x_nxt} < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync    <= ({1'b0, y_nxt} >= VS_BEG && {1'b0, y_nxt} < VS_END) ? SYNC_POL : ~SYNC_POL;
            video_on <= ({1'b0, x_nxt} < H_VIS) && ({1'b0, y_nxt} < V_VIS);
        end
    end
    assign vga.p_tick      = p_tick;
    assign vga.x_pos       = x_pos;
    assign vga.y_pos       = y_pos;
    assign vga.hsync       = hsync;
    assign vga.vsync       = vsync;
    assign vga.video_on    = video_on;
    assign vga.line_start  = p_tick && x_pos == '0;
    assign vga.frame_start = p_tick && x_pos == '0 && y_pos == '0;
endmodule
